// File: rtl/srl_fifo_rd_if.sv
// srl_fifo_rd_if - handshake bundle for the SRL-backed FWFT FIFO.
//   Write side : I_DATA / I_VALID in, I_READY out (space in SRL storage)
//   Read side  : O_DATA / O_VALID out (output register), O_READY in
//   COUNT      : words held, SRL level plus the output register
// Modports:
//   slave  - the FIFO itself
//   master - the producer/consumer environment around it
interface srl_fifo_rd_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 2);

  logic [WIDTH-1:0] I_DATA;
  logic             I_VALID;
  logic             I_READY;
  logic [WIDTH-1:0] O_DATA;
  logic             O_VALID;
  logic             O_READY;
  logic [CW-1:0]    COUNT;

  modport slave (
    input  I_DATA, I_VALID, O_READY,
    output I_READY, O_DATA, O_VALID, COUNT
  );

  modport master (
    output I_DATA, I_VALID, O_READY,
    input  I_READY, O_DATA, O_VALID, COUNT
  );
endinterface

// File: rtl/srl_fifo_rd.sv
// srl_fifo_rd - first-word-fall-through FIFO on SRL-style storage.
//   Writes shift into a DEPTH-deep shift register; the oldest word sits at
//   index level-1 and is moved into a registered output stage whenever that
//   stage is empty or being drained. Capacity is DEPTH+1 words.
// Ports:
//   CLK    - only clock (active edge flipped when IS_CLK_INVERTED=1)
//   RST_N  - async assert, active low; clears control state, not storage
//   bus    - srl_fifo_rd_if.slave (I_DATA/I_VALID/I_READY,
//            O_DATA/O_VALID/O_READY, COUNT)
module srl_fifo_rd #(
  parameter int   WIDTH           = 8,
  parameter int   DEPTH           = 16,
  parameter logic IS_CLK_INVERTED = 1'b0
) (
  input logic          CLK,
  input logic          RST_N,
  srl_fifo_rd_if.slave bus
);

  localparam int LW = $clog2(DEPTH + 1);  // level: 0..DEPTH
  localparam int AW = $clog2(DEPTH);      // SRL address
  localparam int CW = $clog2(DEPTH + 2);  // COUNT: 0..DEPTH+1

  if (DEPTH != 16 && DEPTH != 32) begin : g_bad_depth
    $error("srl_fifo_rd: DEPTH must be 16 or 32");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("srl_fifo_rd: WIDTH must be 1..64");
  end

  // Single clock net for every flop so the inversion option moves all state.
  logic clk_act;
  assign clk_act = CLK ^ IS_CLK_INVERTED;

  logic [DEPTH-1:0][WIDTH-1:0] srl;
  logic [LW-1:0]               level;
  logic [WIDTH-1:0]            o_data_q;
  logic                        o_valid_q;

  logic          push, load;
  logic [AW-1:0] rd_addr;
  logic [WIDTH-1:0] head;

  assign bus.I_READY = RST_N && (level < LW'(DEPTH));
  assign push        = bus.I_VALID && bus.I_READY;
  assign load        = (level != '0) && (!o_valid_q || bus.O_READY);

  // level-1 wraps when empty; the word read then is ignored because load=0.
  assign rd_addr = AW'(level - LW'(1));
  assign head    = srl[rd_addr];

  // Storage has no reset, like the SRL primitive it models.
  always_ff @(posedge clk_act) begin
    if (push) srl <= {srl[DEPTH-2:0], bus.I_DATA};
  end

  always_ff @(posedge clk_act or negedge RST_N) begin
    if (!RST_N) begin
      level     <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
    end else begin
      if (load) begin
        o_data_q  <= head;
        o_valid_q <= 1'b1;
      end else if (o_valid_q && bus.O_READY) begin
        o_valid_q <= 1'b0;
      end
      // Push+load together: the loaded word was at level-1 before the shift
      // and the new word refills the slot, so level stays put.
      case ({push, load})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign bus.O_DATA  = o_data_q;
  assign bus.O_VALID = o_valid_q;
  assign bus.COUNT   = CW'(level) + CW'(o_valid_q);

endmodule

// File: tb/tb_srl_fifo_rd.sv
// tb_srl_fifo_rd - drives DEPTH=16 and DEPTH=32 instances with identical
// stimulus and checks each against a queue-based reference model plus an
// in-order scoreboard of accepted words.
module tb_srl_fifo_rd;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] i_data  = '0;
  logic       i_valid = 1'b0;
  logic       o_ready = 1'b0;

  always #5 CLK = ~CLK;

  srl_fifo_rd_if #(.WIDTH(8), .DEPTH(16)) b16 ();
  srl_fifo_rd_if #(.WIDTH(8), .DEPTH(32)) b32 ();

  assign b16.I_DATA  = i_data;
  assign b16.I_VALID = i_valid;
  assign b16.O_READY = o_ready;
  assign b32.I_DATA  = i_data;
  assign b32.I_VALID = i_valid;
  assign b32.O_READY = o_ready;

  srl_fifo_rd #(.WIDTH(8), .DEPTH(16), .IS_CLK_INVERTED(1'b0)) u16 (
    .CLK(CLK), .RST_N(RST_N), .bus(b16));
  srl_fifo_rd #(.WIDTH(8), .DEPTH(32), .IS_CLK_INVERTED(1'b0)) u32 (
    .CLK(CLK), .RST_N(RST_N), .bus(b32));

  logic       d_ir  [2];
  logic       d_ov  [2];
  logic [7:0] d_od  [2];
  logic [31:0] d_cnt[2];

  assign d_ir[0]  = b16.I_READY;
  assign d_ov[0]  = b16.O_VALID;
  assign d_od[0]  = b16.O_DATA;
  assign d_cnt[0] = 32'(b16.COUNT);
  assign d_ir[1]  = b32.I_READY;
  assign d_ov[1]  = b32.O_VALID;
  assign d_od[1]  = b32.O_DATA;
  assign d_cnt[1] = 32'(b32.COUNT);

  // Reference model: words in storage (front = oldest), output register.
  logic [7:0] mq   [2][$];
  logic [7:0] sent [2][$];
  bit         mov  [2];
  logic [7:0] mod  [2];
  int         nx   [2];

  int total = 0;
  int bad   = 0;

  function automatic int dep(input int i);
    return (i == 0) ? 16 : 32;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      sent[i].delete();
      mov[i] = 1'b0;
      mod[i] = '0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i_ready%0d", dep(i)), 32'(d_ir[i]),
          32'(RST_N && (mq[i].size() < dep(i))));
      chk($sformatf("o_valid%0d", dep(i)), 32'(d_ov[i]), 32'(mov[i]));
      chk($sformatf("o_data%0d", dep(i)),  32'(d_od[i]), 32'(mod[i]));
      chk($sformatf("count%0d", dep(i)),   d_cnt[i], 32'(mq[i].size() + int'(mov[i])));
    end
  endtask

  // Inputs are already set; called just after a negedge.
  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      if (RST_N && d_ov[i] && o_ready) begin
        nx[i]++;
        if (sent[i].size() == 0)
          chk($sformatf("xfer_empty%0d", dep(i)), 32'(d_ov[i]), 32'd0);
        else
          chk($sformatf("xfer%0d", dep(i)), 32'(d_od[i]), 32'(sent[i].pop_front()));
      end
    end
    for (int i = 0; i < 2; i++) begin
      bit ir, pu, ld;
      ir = RST_N && (mq[i].size() < dep(i));
      pu = i_valid && ir;
      ld = RST_N && (mq[i].size() != 0) && (!mov[i] || o_ready);
      if (!RST_N) begin
        // held in reset: nothing moves
      end else if (ld) begin
        mod[i] = mq[i].pop_front();
        mov[i] = 1'b1;
      end else if (mov[i] && o_ready) begin
        mov[i] = 1'b0;
      end
      if (pu) begin
        mq[i].push_back(i_data);
        sent[i].push_back(i_data);
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic drain(input int n);
    i_valid = 1'b0;
    o_ready = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    model_reset();
    nx[0] = 0;
    nx[1] = 0;

    // Reset then idle
    @(negedge CLK);
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (3) tick();
    chk("idle_ready16", 32'(d_ir[0]), 32'd1);
    chk("idle_count16", d_cnt[0], 32'd0);

    // Single word, two-edge latency
    i_valid = 1'b1; i_data = 8'hA5; o_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("single_cnt_a", d_cnt[0], 32'd1);
    chk("single_ov_a", 32'(d_ov[0]), 32'd0);
    tick();
    chk("single_ov_b", 32'(d_ov[0]), 32'd1);
    chk("single_od_b", 32'(d_od[0]), 32'hA5);
    chk("single_cnt_b", d_cnt[0], 32'd1);
    tick();
    chk("single_cnt_c", d_cnt[0], 32'd0);
    repeat (2) tick();

    // Fill to full under backpressure; 18th word must be held off
    o_ready = 1'b0;
    for (int k = 0; k < 18; k++) begin
      i_valid = 1'b1;
      i_data  = 8'(k);
      tick();
    end
    chk("full_count16", d_cnt[0], 32'd17);
    chk("full_ready16", 32'(d_ir[0]), 32'd0);
    tick();
    chk("full_hold16", d_cnt[0], 32'd17);
    drain(40);

    // Steady state: level 5 plus output register, push and pop every cycle
    o_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_valid = 1'b1;
      i_data  = 8'(8'h40 + k);
      tick();
    end
    chk("steady_pre16", d_cnt[0], 32'd6);
    o_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      i_data = 8'(8'h50 + k);
      tick();
      chk("steady_cnt16", d_cnt[0], 32'd6);
      chk("steady_cnt32", d_cnt[1], 32'd6);
    end
    drain(40);

    // Random traffic, alternating then random backpressure
    nx[0] = 0;
    nx[1] = 0;
    for (int c = 0; c < 600; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = 8'($urandom);
      o_ready = (c < 100) ? ((c % 2) == 0) : 1'($urandom_range(0, 1));
      tick();
    end
    drain(40);
    chk("words16", 32'(nx[0] >= 200), 32'd1);
    chk("words32", 32'(nx[1] >= 200), 32'd1);

    // Asynchronous reset mid-stream with COUNT=9
    o_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      i_valid = 1'b1;
      i_data  = 8'(8'h90 + k);
      tick();
    end
    i_valid = 1'b0;
    chk("pre_rst_cnt16", d_cnt[0], 32'd9);
    chk("pre_rst_cnt32", d_cnt[1], 32'd9);
    #2 RST_N = 1'b0;
    #1;
    model_reset();
    chk("rst_ov16", 32'(d_ov[0]), 32'd0);
    chk("rst_cnt16", d_cnt[0], 32'd0);
    chk("rst_ir16", 32'(d_ir[0]), 32'd0);
    chk("rst_cnt32", d_cnt[1], 32'd0);
    @(negedge CLK);
    compare_all();
    tick();
    RST_N = 1'b1;
    i_valid = 1'b1; i_data = 8'h3C; o_ready = 1'b0;
    tick();
    i_valid = 1'b0;
    tick();
    chk("post_rst_ov16", 32'(d_ov[0]), 32'd1);
    chk("post_rst_od16", 32'(d_od[0]), 32'h3C);
    chk("post_rst_od32", 32'(d_od[1]), 32'h3C);
    drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
